// File: rtl/ramio_lsu.sv
// ramio_lsu: CPU load/store unit placed directly upstream of the unified
// SDRAM cache. It takes one byte, half-word or word request at any byte
// address and issues one or two word-aligned cache accesses, each followed
// by a one-cycle hold. It then returns extended load data and a one-cycle
// completion pulse.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_*               CPU request (valid/ready handshake, accepted in Idle)
//   rsp_*               completion pulse, error flag, load data
//   c_enable/c_address/c_data_in/c_write_enable   to cache
//   c_data_out/c_data_out_ready/c_busy            from cache
//
// Parameter:
//   SplitMisaligned     1: word-crossing accesses are split in two;
//                       0: they are rejected with rsp_error
module ramio_lsu #(
  parameter bit SplitMisaligned = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign_extend,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [31:0] rsp_rdata,
  output logic        c_enable,
  output logic [31:0] c_address,
  output logic [31:0] c_data_in,
  output logic [3:0]  c_write_enable,
  input  logic [31:0] c_data_out,
  input  logic        c_data_out_ready,
  input  logic        c_busy
);

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    HOLD0,
    ACC1,
    HOLD1,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] w0_q, w0_d;
  logic [31:0] w1_q, w1_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
    return (size == 2'd1 && off == 2'd3) || (size == 2'd2 && off != 2'd0);
  endfunction

  logic [1:0]  off;
  logic        split;
  logic [31:0] word0;
  logic [31:0] word1;
  logic [3:0]  mask0;
  logic [3:0]  mask1;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [5:0]  sh1;
  logic [31:0] lane;
  logic [31:0] load_result;

  // Address decode, lane placement and load extraction from latched request.
  always_comb begin
    off   = addr_q[1:0];
    split = crosses_word(size_q, off);
    word0 = {addr_q[31:2], 2'b00};
    word1 = word0 + 32'd4;   // wraps modulo 2^32

    case (size_q)
      2'd0:    mask0 = 4'b0001 << off;
      2'd1:    mask0 = 4'b0011 << off;
      default: mask0 = 4'b1111 << off;
    endcase
    // Second access only exists for crossing half/word, so off is non-zero here.
    mask1 = (size_q == 2'd2) ? (4'b1111 >> (3'd4 - {1'b0, off})) : 4'b0001;

    data0 = wdata_q << {off, 3'b000};
    sh1   = 6'd32 - {1'b0, off, 3'b000};
    data1 = wdata_q >> sh1;

    // Both captured words form a 64-bit window; the result starts at byte off.
    lane = 32'({w1_q, w0_q} >> {off, 3'b000});
    case (size_q)
      2'd0:    load_result = sext_q ? {{24{lane[7]}}, lane[7:0]}   : {24'd0, lane[7:0]};
      2'd1:    load_result = sext_q ? {{16{lane[15]}}, lane[15:0]} : {16'd0, lane[15:0]};
      default: load_result = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    sext_d      = sext_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          sext_d  = req_sign_extend;
          addr_d  = req_address;
          wdata_d = req_wdata;
          w0_d    = '0;
          w1_d    = '0;
          if (req_size == 2'd3 ||
              (crosses_word(req_size, req_address[1:0]) && !SplitMisaligned)) begin
            state_d     = RESP;
            rsp_error_d = 1'b1;
          end else begin
            state_d = ACC0;
          end
        end
      end
      ACC0: begin
        if (!c_busy) begin
          if (!write_q) w0_d = c_data_out;
          state_d = HOLD0;
        end
      end
      HOLD0: begin
        if (split) begin
          state_d = ACC1;
        end else begin
          state_d     = RESP;
          rsp_rdata_d = write_q ? '0 : load_result;
        end
      end
      ACC1: begin
        if (!c_busy) begin
          if (!write_q) w1_d = c_data_out;
          state_d = HOLD1;
        end
      end
      HOLD1: begin
        state_d     = RESP;
        rsp_rdata_d = write_q ? '0 : load_result;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= '0;
      sext_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Cache-side outputs; hold cycles keep address/enable but never write.
  always_comb begin
    c_enable       = 1'b0;
    c_address      = '0;
    c_data_in      = '0;
    c_write_enable = '0;
    case (state_q)
      ACC0: begin
        c_enable       = 1'b1;
        c_address      = word0;
        c_data_in      = data0;
        c_write_enable = write_q ? mask0 : 4'b0000;
      end
      HOLD0: begin
        c_enable  = 1'b1;
        c_address = word0;
        c_data_in = data0;
      end
      ACC1: begin
        c_enable       = 1'b1;
        c_address      = word1;
        c_data_in      = data1;
        c_write_enable = write_q ? mask1 : 4'b0000;
      end
      HOLD1: begin
        c_enable  = 1'b1;
        c_address = word1;
        c_data_in = data1;
      end
      default: begin
      end
    endcase
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

  // A load access that is not stalled must see read data from the cache.
  read_data_present: assert property (@(posedge clk) disable iff (rst)
    ((state_q == ACC0 || state_q == ACC1) && !write_q && !c_busy) |-> c_data_out_ready);

endmodule

// File: tb/tb_ramio_lsu.sv
// Testbench for ramio_lsu: directed test-plan cases plus randomized requests,
// checked cycle by cycle against a byte-level reference model.
module tb_ramio_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_sign_extend = 1'b0;
  logic [31:0] req_address = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;
  logic        c_enable;
  logic [31:0] c_address;
  logic [31:0] c_data_in;
  logic [3:0]  c_write_enable;
  logic [31:0] c_data_out;
  logic        c_data_out_ready;
  logic        c_busy;

  logic        ns_valid = 1'b0;
  logic        ns_ready;
  logic        ns_rsp_valid;
  logic        ns_rsp_error;
  logic [31:0] ns_rsp_rdata;
  logic        ns_c_enable;
  logic [31:0] ns_c_address;
  logic [31:0] ns_c_data_in;
  logic [3:0]  ns_c_write_enable;

  ramio_lsu #(.SplitMisaligned(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_sign_extend(req_sign_extend),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .c_enable(c_enable), .c_address(c_address), .c_data_in(c_data_in),
    .c_write_enable(c_write_enable), .c_data_out(c_data_out),
    .c_data_out_ready(c_data_out_ready), .c_busy(c_busy)
  );

  ramio_lsu #(.SplitMisaligned(1'b0)) dut_nosplit (
    .clk(clk), .rst(rst),
    .req_valid(ns_valid), .req_ready(ns_ready), .req_write(req_write),
    .req_size(req_size), .req_sign_extend(req_sign_extend),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(ns_rsp_valid), .rsp_error(ns_rsp_error), .rsp_rdata(ns_rsp_rdata),
    .c_enable(ns_c_enable), .c_address(ns_c_address), .c_data_in(ns_c_data_in),
    .c_write_enable(ns_c_write_enable), .c_data_out(32'h0),
    .c_data_out_ready(1'b1), .c_busy(1'b0)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- cache model (4 KB, addresses alias modulo 4096) ----------
  logic [31:0] cmem [0:1023];
  logic        mem_init = 1'b1;
  int unsigned busy_left = 0;
  int unsigned busy_req  = 0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (m[l]) r[8*l +: 8] = nw[8*l +: 8];
    return r;
  endfunction

  assign c_busy           = (busy_left != 0);
  assign c_data_out       = cmem[c_address[11:2]];
  assign c_data_out_ready = c_enable && !c_busy;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) cmem[i] <= init_word(i);
    end else if (c_enable && !c_busy && c_write_enable != 4'b0000) begin
      cmem[c_address[11:2]] <= merge(cmem[c_address[11:2]], c_data_in, c_write_enable);
    end
  end

  // Miss length applies to the first access of the accepted request.
  always @(posedge clk) begin
    if (rst) busy_left <= 0;
    else if (req_valid && req_ready) busy_left <= busy_req;
    else if (c_enable && busy_left != 0) busy_left <= busy_left - 1;
  end

  // ---------------- reference model -----------------------------------------
  logic [7:0] ref_mem [0:4095];

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
    logic        rsp;
    logic        err;
    logic [31:0] rdata;
  } rec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } wr_t;

  rec_t exp_q [$];
  wr_t  wlog  [$];

  function automatic rec_t mk(input logic en, input logic [31:0] a, input logic [3:0] we,
                              input logic [31:0] d, input logic rsp, input logic err,
                              input logic [31:0] rd);
    rec_t r;
    r.en = en; r.addr = a; r.we = we; r.data = d; r.rsp = rsp; r.err = err; r.rdata = rd;
    return r;
  endfunction

  function automatic logic [31:0] lanemask(input logic [3:0] m);
    logic [31:0] r;
    for (int l = 0; l < 4; l++) r[8*l +: 8] = {8{m[l]}};
    return r;
  endfunction

  function automatic wr_t wlog_at(input int i);
    wr_t w;
    w.addr = '0; w.we = '0; w.data = '0;
    if (i < wlog.size()) w = wlog[i];
    return w;
  endfunction

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned last_lat = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_rdata = '0;
  int unsigned rsp_count = 0;
  logic        rst_at_edge = 1'b1;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // ---------------- compare process -----------------------------------------
  always @(negedge clk) begin
    rec_t r;
    if (rsp_valid) rsp_count++;
    if (rst) begin
      check("ready_in_reset", 32'(req_ready), 32'd0);
      if (rst_at_edge) begin
        check("rst_c_enable", 32'(c_enable), 32'd0);
        check("rst_c_write_enable", 32'(c_write_enable), 32'd0);
        check("rst_c_address", c_address, 32'd0);
        check("rst_c_data_in", c_data_in, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
      end
    end else if (exp_q.size() == 0) begin
      check("idle_req_ready", 32'(req_ready), 32'd1);
      check("idle_c_enable", 32'(c_enable), 32'd0);
      check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    end else begin
      r = exp_q.pop_front();
      check("busy_req_ready", 32'(req_ready), 32'd0);
      check("c_enable", 32'(c_enable), 32'(r.en));
      if (r.en) begin
        check("c_address", c_address, r.addr);
        check("c_write_enable", 32'(c_write_enable), 32'(r.we));
        if (r.we != 4'b0000)
          check("c_data_in", c_data_in & lanemask(r.we), r.data & lanemask(r.we));
      end
      check("rsp_valid", 32'(rsp_valid), 32'(r.rsp));
      if (r.rsp) begin
        check("rsp_error", 32'(rsp_error), 32'(r.err));
        check("rsp_rdata", rsp_rdata, r.rdata);
        last_lat   = cyc - acc_cyc + 1;
        last_err   = rsp_error;
        last_rdata = rsp_rdata;
      end
    end
    if (!rst && c_enable && !c_busy && c_write_enable != 4'b0000) begin
      wr_t w;
      w.addr = c_address; w.we = c_write_enable; w.data = c_data_in;
      wlog.push_back(w);
    end
  end

  // ---------------- driver --------------------------------------------------
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
    exp_q.delete();
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input int unsigned busy);
    int unsigned n;
    int unsigned nacc;
    logic        split;
    logic        err;
    logic [31:0] wa;
    logic [31:0] d;
    logic [31:0] ba;
    logic [31:0] val;
    logic [3:0]  m;
    n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    split = (32'(a[1:0]) + n) > 32'd4;
    err   = (sz == 2'd3);
    wait_idle();
    req_write = wr; req_size = sz; req_sign_extend = sx;
    req_address = a; req_wdata = wd;
    busy_req  = err ? 0 : busy;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
    if (err) begin
      exp_q.push_back(mk(1'b0, '0, '0, '0, 1'b1, 1'b1, '0));
    end else begin
      nacc = split ? 2 : 1;
      for (int j = 0; j < int'(nacc); j++) begin
        wa = {a[31:2], 2'b00} + 32'(4 * j);
        m  = '0;
        d  = '0;
        for (int i = 0; i < int'(n); i++) begin
          ba = a + 32'(i);
          if (ba[31:2] == wa[31:2]) begin
            m[ba[1:0]] = 1'b1;
            d[8*ba[1:0] +: 8] = wd[8*i +: 8];
          end
        end
        if (!wr) m = '0;
        for (int c = 0; c < ((j == 0) ? int'(busy) : 0) + 1; c++)
          exp_q.push_back(mk(1'b1, wa, m, d, 1'b0, 1'b0, '0));
        exp_q.push_back(mk(1'b1, wa, 4'b0000, '0, 1'b0, 1'b0, '0));
      end
      val = '0;
      for (int i = 0; i < int'(n); i++) begin
        ba = a + 32'(i);
        if (wr) ref_mem[ba[11:0]] = wd[8*i +: 8];
        else    val[8*i +: 8] = ref_mem[ba[11:0]];
      end
      if (!wr && sx && val[8*n-1])
        for (int i = int'(n); i < 4; i++) val[8*i +: 8] = 8'hFF;
      exp_q.push_back(mk(1'b0, '0, '0, '0, 1'b1, 1'b0, wr ? 32'd0 : val));
    end
  endtask

  task automatic ns_req(input logic [1:0] sz, input logic [31:0] a,
                        output int unsigned lat, output logic err, output logic en_seen);
    @(posedge clk); #1;
    req_write = 1'b0; req_size = sz; req_sign_extend = 1'b0;
    req_address = a; req_wdata = '0;
    ns_valid = 1'b1;
    @(posedge clk); #1;
    ns_valid = 1'b0;
    lat = 0; err = 1'b0; en_seen = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      if (ns_c_enable) begin
        en_seen = 1'b1;
        check("ns_c_address", ns_c_address, {a[31:2], 2'b00});
        check("ns_c_write_enable", 32'(ns_c_write_enable), 32'd0);
      end
      if (ns_rsp_valid) begin
        lat = t; err = ns_rsp_error;
        check("ns_rsp_rdata", ns_rsp_rdata, 32'd0);
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus -------------------------------------------------
  initial begin
    int unsigned lat;
    int unsigned snap;
    logic        err;
    logic        en_seen;
    wr_t         w;
    logic [31:0] a;
    logic [1:0]  sz;

    for (int i = 0; i < 1024; i++)
      for (int b = 0; b < 4; b++) begin
        logic [31:0] iw;
        iw = init_word(i);
        ref_mem[4*i + b] = iw[8*b +: 8];
      end

    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    rst = 1'b0;

    // Aligned word store then load.
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_1234, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h100, '0, 0);
    wait_idle();
    check("lw_0x100", last_rdata, 32'h80FF_1234);
    check("lw_latency", last_lat, 32'd3);

    // Extension cases.
    issue(1'b0, 2'd0, 1'b1, 32'h103, '0, 0);  wait_idle();
    check("lb_signed", last_rdata, 32'hFFFF_FF80);
    issue(1'b0, 2'd0, 1'b0, 32'h103, '0, 0);  wait_idle();
    check("lbu", last_rdata, 32'h0000_0080);
    issue(1'b0, 2'd1, 1'b1, 32'h102, '0, 0);  wait_idle();
    check("lh_signed", last_rdata, 32'hFFFF_80FF);

    // Byte store into lane 1.
    wlog.delete();
    issue(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB, 0);  wait_idle();
    w = wlog_at(0);
    check("sb_write_count", 32'(wlog.size()), 32'd1);
    check("sb_addr", w.addr, 32'h100);
    check("sb_mask", 32'(w.we), 32'b0010);
    check("sb_data", 32'(w.data[15:8]), 32'hAB);
    issue(1'b0, 2'd2, 1'b0, 32'h100, '0, 0);  wait_idle();
    check("lw_after_sb", last_rdata, 32'h80FF_AB34);

    // Split word store across 0x1FC/0x200.
    wlog.delete();
    issue(1'b1, 2'd2, 1'b0, 32'h1FE, 32'h1122_3344, 0);  wait_idle();
    check("sw_split_latency", last_lat, 32'd5);
    check("sw_split_count", 32'(wlog.size()), 32'd2);
    w = wlog_at(0);
    check("sw_split_addr0", w.addr, 32'h1FC);
    check("sw_split_mask0", 32'(w.we), 32'b1100);
    check("sw_split_data0", 32'(w.data[31:16]), 32'h3344);
    w = wlog_at(1);
    check("sw_split_addr1", w.addr, 32'h200);
    check("sw_split_mask1", 32'(w.we), 32'b0011);
    check("sw_split_data1", 32'(w.data[15:0]), 32'h1122);
    issue(1'b0, 2'd2, 1'b0, 32'h1FE, '0, 0);  wait_idle();
    check("lw_split", last_rdata, 32'h1122_3344);

    // Miss: 20 busy cycles on the only access.
    snap = rsp_count;
    issue(1'b0, 2'd2, 1'b0, 32'h4000, '0, 20);  wait_idle();
    check("miss_latency", last_lat, 32'd23);
    check("miss_rsp_once", rsp_count - snap, 32'd1);

    // Reserved size.
    issue(1'b0, 2'd3, 1'b0, 32'h100, '0, 0);  wait_idle();
    check("size3_latency", last_lat, 32'd1);
    check("size3_error", 32'(last_err), 32'd1);

    // Address wrap on a split load.
    issue(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFE, '0, 0);  wait_idle();
    check("wrap_latency", last_lat, 32'd5);

    // Instance with splitting disabled.
    ns_req(2'd1, 32'h3, lat, err, en_seen);
    check("ns_lh3_latency", lat, 32'd1);
    check("ns_lh3_error", 32'(err), 32'd1);
    check("ns_lh3_no_access", 32'(en_seen), 32'd0);
    ns_req(2'd2, 32'h4, lat, err, en_seen);
    check("ns_lw4_latency", lat, 32'd3);
    check("ns_lw4_error", 32'(err), 32'd0);

    // Reset while the second access of a split load is on the bus.
    snap = rsp_count;
    issue(1'b0, 2'd2, 1'b0, 32'h1FE, '0, 0);
    @(posedge clk); @(posedge clk); #1;
    check("acc1_c_address", c_address, 32'h200);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    wait_idle();
    wait_idle();
    check("reset_no_rsp", rsp_count - snap, 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      sz = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom();
      if ($urandom_range(0, 3) == 0) a[31:12] = '1;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(),
            ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    @(posedge clk); #1;

    for (int i = 0; i < 1024; i++)
      check("mem_image", cmem[i],
            {ref_mem[4*i + 3], ref_mem[4*i + 2], ref_mem[4*i + 1], ref_mem[4*i]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
